rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares one resource between requesters req[3:0]. It holds a 2-bit owner index and turns it into the one-hot grant vector through the team's 2-to-4 decoder. Grants are held until the owner releases, drops its request, or hits a hold timeout. It sits in front of any shared datapath resource, such as a bus port or a register-file write port.

---
 rtl/rr_arbiter4_pkg.sv | 28 ++
 rtl/rr_arbiter4_dec2to4.sv | 15 +
 rtl/rr_arbiter4.sv | 86 ++++++++
 tb/tb_rr_arbiter4.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter: state
// encoding, requester count and the rotating-priority scan.
package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  // First requester at or after ptr, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter4_dec2to4.sv
// 2-to-4 one-hot decoder with an enable; the output is all zero when disabled.
module dec2to4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) begin
      y[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with release, request-drop and hold
// timeout exits. Grant is decoded from the registered owner index.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [1:0]         owner,
  output logic               timeout,
  output logic               state_dbg
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
  logic              release_now;
  logic              limit_now;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 2'd0;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    release_now = done || !req[owner_q];
    limit_now   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d    = rr_pick(req, ptr_q);
          state_d    = S_GRANT;
          hold_cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (release_now || limit_now) begin
          state_d   = S_IDLE;
          ptr_d     = owner_q + 2'd1;
          // A coinciding release or request drop wins over the timeout.
          timeout_d = !release_now;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
    endcase
  end

  dec2to4 u_dec (
    .sel (owner_q),
    .en  (state_q == S_GRANT),
    .y   (grant)
  );

  assign grant_valid = (state_q == S_GRANT);
  assign owner       = owner_q;
  assign timeout     = timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: reset, rotation, wrap, timeout, release
// priority, request drop and asynchronous reset during a grant.
module tb_rr_arbiter4;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] owner;
  logic       timeout;
  logic       state_dbg;

  int checks = 0;
  int fails  = 0;

  rr_arbiter4 #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .owner       (owner),
    .timeout     (timeout),
    .state_dbg   (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // Invariants sampled on the falling edge: never multi-hot, valid tracks grant.
  always @(negedge clock) begin
    checks++;
    if ($countones(grant) > 1) begin
      fails++;
      $display("FAIL onehot: grant=%b is multi-hot", grant);
    end
    checks++;
    if (grant_valid !== (|grant)) begin
      fails++;
      $display("FAIL valid_or: grant_valid=%b expected %b", grant_valid, |grant);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    done  = 1'b0;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || owner !== 2'd0 ||
        timeout !== 1'b0 || state_dbg !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: grant=%b gv=%b owner=%0d to=%b st=%b expected 0000 0 0 0 0",
               grant, grant_valid, owner, timeout, state_dbg);
    end
    reset = 1'b0;
    req   = 4'b0100;
    checks++;
    if (grant !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release_nocomb: grant=%b expected 0000", grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2 || grant_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_grant: grant=%b owner=%0d gv=%b expected 0100 2 1",
               grant, owner, grant_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (grant !== exp_seq[i]) begin
        fails++;
        $display("FAIL round_robin[%0d]: grant=%b expected %b", i, grant, exp_seq[i]);
      end
      done = (exp_seq[i] != 4'b0000);
    end
    done = 1'b0;
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000 || owner !== 2'd3) begin
      fails++;
      $display("FAIL wrap_owner3: grant=%b owner=%0d expected 1000 3", grant, owner);
    end
    req  = 4'b1001;
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (grant !== 4'b0000 || owner !== 2'd3) begin
      fails++;
      $display("FAIL wrap_idle: grant=%b owner=%0d expected 0000 3", grant, owner);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      fails++;
      $display("FAIL wrap_next: grant=%b owner=%0d expected 0001 0", grant, owner);
    end
  endtask

  task automatic test_timeout();
    int held;
    do_reset();
    req  = 4'b0011;
    held = 0;
    tick();
    for (int i = 0; i < 12; i++) begin
      if (grant == 4'b0001) held++;
      if (grant != 4'b0001) break;
      checks++;
      if (timeout !== 1'b0) begin
        fails++;
        $display("FAIL timeout_early[%0d]: timeout=%b expected 0", i, timeout);
      end
      tick();
    end
    checks++;
    if (held != 8) begin
      fails++;
      $display("FAIL timeout_hold_len: held=%0d cycles expected 8", held);
    end
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout_pulse: grant=%b timeout=%b expected 0000 1", grant, timeout);
    end
    tick();
    checks++;
    if (grant !== 4'b0010 || timeout !== 1'b0 || owner !== 2'd1) begin
      fails++;
      $display("FAIL timeout_next: grant=%b timeout=%b owner=%0d expected 0010 0 1",
               grant, timeout, owner);
    end
  endtask

  task automatic test_release_priority();
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      req = 4'b0001;
      tick();
      for (int i = 0; i < 7; i++) tick();
      checks++;
      if (grant !== 4'b0001) begin
        fails++;
        $display("FAIL relprio_held[%0d]: grant=%b expected 0001", mode, grant);
      end
      if (mode == 0) done = 1'b1;
      else           req  = 4'b0000;
      tick();
      done = 1'b0;
      req  = 4'b0000;
      checks++;
      if (grant !== 4'b0000 || timeout !== 1'b0) begin
        fails++;
        $display("FAIL relprio_exit[%0d]: grant=%b timeout=%b expected 0000 0",
                 mode, grant, timeout);
      end
      tick();
      checks++;
      if (timeout !== 1'b0) begin
        fails++;
        $display("FAIL relprio_after[%0d]: timeout=%b expected 0", mode, timeout);
      end
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0101;
    tick();
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2) begin
      fails++;
      $display("FAIL nonowner_change: grant=%b owner=%0d expected 0100 2", grant, owner);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL req_drop: grant=%b gv=%b timeout=%b expected 0000 0 0",
               grant, grant_valid, timeout);
    end
  endtask

  task automatic test_done_in_idle();
    do_reset();
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0001;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("FAIL done_idle_ignored: grant=%b expected 0001", grant);
    end
  endtask

  task automatic test_midgrant_reset();
    do_reset();
    req = 4'b0100;
    tick();
    req  = 4'b1000;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      fails++;
      $display("FAIL midreset_setup: grant=%b expected 1000", grant);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || owner !== 2'd0) begin
      fails++;
      $display("FAIL midreset_async: grant=%b gv=%b owner=%0d expected 0000 0 0",
               grant, grant_valid, owner);
    end
    tick();
    reset = 1'b0;
    req   = 4'b1001;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("FAIL midreset_ptr: grant=%b expected 0001", grant);
    end
    req = 4'b0010;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL midreset_regrant: grant=%b expected 0010", grant);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    test_reset();
    test_round_robin();
    test_pointer_wrap();
    test_timeout();
    test_release_priority();
    test_req_drop();
    test_done_in_idle();
    test_midgrant_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
